// File: rtl/ps_servo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ps_servo_ctrl
// Description : Phase-error servo for an MMCM dynamic phase shifter. A
//               saturating accumulator integrates the phase error, a
//               power-of-two moving average smooths it, and a step FSM
//               issues single psen pulses (auto or manual) with a psdone
//               timeout and an enforced idle gap between steps.
// Revision    : 1.0 - initial release
// ============================================================================
module ps_servo_ctrl #(
    parameter int WIDTH        = 32,
    parameter int FILT_LOG2    = 3,
    parameter int MIN_GAP      = 16,
    parameter int DONE_TIMEOUT = 64
) (
    input  logic                    clk,
    input  logic                    reset_in_n,
    input  logic                    err_valid,
    input  logic signed [WIDTH-1:0] err_in,
    input  logic                    auto_mode,
    input  logic                    hold,
    input  logic        [WIDTH-1:0] deadband,
    input  logic                    man_psen,
    input  logic                    man_incdec,
    input  logic                    psdone,
    output logic                    psen,
    output logic                    psincdec,
    output logic signed [WIDTH-1:0] accum_out,
    output logic signed [WIDTH-1:0] filt_out,
    output logic signed [31:0]      ps_count,
    output logic                    busy,
    output logic                    timeout_err
);

    localparam int c_DEPTH = 1 << FILT_LOG2;
    localparam int c_SW    = WIDTH + FILT_LOG2;
    // Pointer keeps at least one bit so a depth-1 filter still elaborates.
    localparam int c_PW    = (FILT_LOG2 > 0) ? FILT_LOG2 : 1;

    localparam logic [c_PW-1:0]       c_PTR_LAST  = c_PW'(c_DEPTH - 1);
    localparam logic [FILT_LOG2:0]    c_FILL_FULL = (FILT_LOG2 + 1)'(c_DEPTH);
    localparam logic [31:0]           c_TMO       = 32'(DONE_TIMEOUT);
    localparam logic [31:0]           c_GAP       = 32'(MIN_GAP);
    localparam logic signed [WIDTH-1:0] c_ACC_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] c_ACC_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_PULSE     = 2'd1,
        S_WAIT_DONE = 2'd2,
        S_GAP       = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Accumulator and filter
    // ------------------------------------------------------------------
    logic signed [WIDTH:0]     w_acc_sum;
    logic signed [WIDTH-1:0]   w_acc_next;
    logic signed [WIDTH-1:0]   w_evict;
    logic signed [c_SW-1:0]    w_sum_next;
    logic signed [WIDTH-1:0]   w_filt_next;

    logic signed [WIDTH-1:0]   r_buf [c_DEPTH];
    logic        [c_PW-1:0]    r_wr_ptr;
    logic        [FILT_LOG2:0] r_fill;
    logic signed [c_SW-1:0]    r_sum;

    // Saturating add and running-sum update; evicted entry reads 0 until the buffer has filled.
    always_comb begin
        w_acc_sum  = {accum_out[WIDTH-1], accum_out} + {err_in[WIDTH-1], err_in};
        w_acc_next = accum_out;
        if (!hold) begin
            if (w_acc_sum[WIDTH] != w_acc_sum[WIDTH-1]) begin
                w_acc_next = w_acc_sum[WIDTH] ? c_ACC_MIN : c_ACC_MAX;
            end else begin
                w_acc_next = w_acc_sum[WIDTH-1:0];
            end
        end
        w_evict     = (r_fill == c_FILL_FULL) ? r_buf[r_wr_ptr] : '0;
        w_sum_next  = r_sum + c_SW'(w_acc_next) - c_SW'(w_evict);
        w_filt_next = WIDTH'(w_sum_next >>> FILT_LOG2);
    end

    // Accumulator, running sum, filter output and buffer bookkeeping on each valid sample.
    always_ff @(posedge clk) begin
        if (!reset_in_n) begin
            accum_out <= '0;
            filt_out  <= '0;
            r_sum     <= '0;
            r_wr_ptr  <= '0;
            r_fill    <= '0;
        end else if (err_valid) begin
            accum_out <= w_acc_next;
            filt_out  <= w_filt_next;
            r_sum     <= w_sum_next;
            r_wr_ptr  <= (r_wr_ptr == c_PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
            if (r_fill != c_FILL_FULL) begin
                r_fill <= r_fill + 1'b1;
            end
        end
    end

    // Circular sample buffer holding post-update accumulator values.
    always_ff @(posedge clk) begin
        if (!reset_in_n) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_buf[i] <= '0;
            end
        end else if (err_valid) begin
            r_buf[r_wr_ptr] <= w_acc_next;
        end
    end

    // ------------------------------------------------------------------
    // Step FSM
    // ------------------------------------------------------------------
    state_t             r_state, w_state_next;
    logic [31:0]        r_cnt, w_cnt_next;
    logic               r_incdec, w_incdec_next;
    logic signed [31:0] r_ps_count, w_ps_count_next;
    logic               r_tmo, w_tmo_next;
    logic [WIDTH-1:0]   w_filt_abs;
    logic               w_filt_pos;
    logic               w_auto_req;

    // State register and per-step bookkeeping.
    always_ff @(posedge clk) begin
        if (!reset_in_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_incdec   <= 1'b0;
            r_ps_count <= '0;
            r_tmo      <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            r_incdec   <= w_incdec_next;
            r_ps_count <= w_ps_count_next;
            r_tmo      <= w_tmo_next;
        end
    end

    // Next-state logic: trigger decision only in IDLE; psdone wins over a coincident timeout.
    always_comb begin
        w_state_next    = r_state;
        w_cnt_next      = r_cnt;
        w_incdec_next   = r_incdec;
        w_ps_count_next = r_ps_count;
        w_tmo_next      = r_tmo;

        w_filt_abs = filt_out[WIDTH-1] ? WIDTH'(-filt_out) : WIDTH'(filt_out);
        w_filt_pos = !filt_out[WIDTH-1] && (|filt_out);
        w_auto_req = auto_mode && !hold && (w_filt_abs > deadband);

        case (r_state)
            S_IDLE: begin
                w_cnt_next = '0;
                if (auto_mode) begin
                    if (w_auto_req) begin
                        w_state_next  = S_PULSE;
                        w_incdec_next = w_filt_pos;
                    end
                end else if (man_psen) begin
                    w_state_next  = S_PULSE;
                    w_incdec_next = man_incdec;
                end
            end
            S_PULSE: begin
                w_state_next = S_WAIT_DONE;
                w_cnt_next   = '0;
            end
            S_WAIT_DONE: begin
                if (psdone) begin
                    w_ps_count_next = r_incdec ? r_ps_count + 32'sd1 : r_ps_count - 32'sd1;
                    w_state_next    = S_GAP;
                    w_cnt_next      = '0;
                end else if (r_cnt + 32'd1 >= c_TMO) begin
                    w_tmo_next   = 1'b1;
                    w_state_next = S_GAP;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + 32'd1;
                end
            end
            S_GAP: begin
                if (r_cnt + 32'd1 >= c_GAP) begin
                    w_state_next = S_IDLE;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + 32'd1;
                end
            end
        endcase
    end

    assign psen        = (r_state == S_PULSE);
    assign busy        = (r_state != S_IDLE);
    assign psincdec    = r_incdec;
    assign ps_count    = r_ps_count;
    assign timeout_err = r_tmo;

endmodule
`default_nettype wire

// File: tb/tb_ps_servo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps_servo_ctrl
// Description : Directed self-checking bench for ps_servo_ctrl with
//               hand-computed expected values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps_servo_ctrl;

    logic        clk;
    logic        reset_in_n;
    logic        err_valid;
    logic [31:0] err_in;
    logic        auto_mode;
    logic        hold;
    logic [31:0] deadband;
    logic        man_psen;
    logic        man_incdec;
    logic        psdone;
    logic        psen;
    logic        psincdec;
    logic [31:0] accum_out;
    logic [31:0] filt_out;
    logic [31:0] ps_count;
    logic        busy;
    logic        timeout_err;

    int n_checks = 0;
    int n_errors = 0;

    ps_servo_ctrl #(
        .WIDTH        (32),
        .FILT_LOG2    (3),
        .MIN_GAP      (16),
        .DONE_TIMEOUT (64)
    ) u_dut (
        .clk         (clk),
        .reset_in_n  (reset_in_n),
        .err_valid   (err_valid),
        .err_in      (err_in),
        .auto_mode   (auto_mode),
        .hold        (hold),
        .deadband    (deadband),
        .man_psen    (man_psen),
        .man_incdec  (man_incdec),
        .psdone      (psdone),
        .psen        (psen),
        .psincdec    (psincdec),
        .accum_out   (accum_out),
        .filt_out    (filt_out),
        .ps_count    (ps_count),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop if anything hangs.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample point is 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_in_n = 1'b0;
        err_valid  = 1'b0;
        psdone     = 1'b0;
        man_psen   = 1'b0;
        tick();
        tick();
        reset_in_n = 1'b1;
    endtask

    task automatic push(input logic [31:0] val);
        err_valid = 1'b1;
        err_in    = val;
        tick();
        err_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
        end
        check("wait_idle_expired", 64'(n >= 100), 64'd0);
    endtask

    initial begin
        int  n;
        logic seen;

        reset_in_n = 1'b0;
        err_valid  = 1'b0;
        err_in     = '0;
        auto_mode  = 1'b0;
        hold       = 1'b0;
        deadband   = 32'hFFFF_FFFF;
        man_psen   = 1'b0;
        man_incdec = 1'b0;
        psdone     = 1'b0;

        // A: reset state
        do_reset();
        check("rst_accum",    64'(accum_out),   64'd0);
        check("rst_filt",     64'(filt_out),    64'd0);
        check("rst_ps_count", 64'(ps_count),    64'd0);
        check("rst_psen",     64'(psen),        64'd0);
        check("rst_busy",     64'(busy),        64'd0);
        check("rst_timeout",  64'(timeout_err), 64'd0);
        check("rst_psincdec", 64'(psincdec),    64'd0);

        // B: eight pushes of +100, then a ninth evicting the first entry
        push(32'd100);
        check("push1_accum", 64'(accum_out), 64'd100);
        check("push1_filt",  64'(filt_out),  64'd12);
        for (int i = 0; i < 3; i++) push(32'd100);
        check("push4_accum", 64'(accum_out), 64'd400);
        check("push4_filt",  64'(filt_out),  64'd125);
        for (int i = 0; i < 4; i++) push(32'd100);
        check("push8_accum", 64'(accum_out), 64'd800);
        check("push8_filt",  64'(filt_out),  64'd450);
        push(32'd100);
        check("push9_accum", 64'(accum_out), 64'd900);
        check("push9_filt",  64'(filt_out),  64'd550);
        tick();
        check("novalid_accum", 64'(accum_out), 64'd900);

        // C: hold freezes the accumulator and blocks auto steps
        hold      = 1'b1;
        auto_mode = 1'b1;
        deadband  = 32'd0;
        seen      = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push(32'd7);
            seen |= psen;
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            seen |= psen;
        end
        check("hold_accum", 64'(accum_out), 64'd900);
        check("hold_filt",  64'(filt_out),  64'd825);
        check("hold_psen",  64'(seen),      64'd0);
        auto_mode = 1'b0;
        hold      = 1'b0;
        deadband  = 32'hFFFF_FFFF;

        // D: auto step with filt_out=+50, psdone after 5 cycles
        do_reset();
        push(32'd400);
        check("auto_filt", 64'(filt_out), 64'd50);
        deadband  = 32'd10;
        auto_mode = 1'b1;
        tick();
        check("auto_psen",     64'(psen),     64'd1);
        check("auto_psincdec", 64'(psincdec), 64'd1);
        tick();
        check("auto_psen_one", 64'(psen), 64'd0);
        check("auto_busy",     64'(busy), 64'd1);
        for (int i = 0; i < 3; i++) tick();
        psdone = 1'b1;
        tick();
        psdone = 1'b0;
        check("auto_ps_count", 64'(ps_count), 64'd1);
        check("auto_hold_dir", 64'(psincdec), 64'd1);
        n = 0;
        while (!psen && n < 100) begin
            tick();
            n++;
        end
        check("gap_found",   64'(n < 100), 64'd1);
        check("gap_min_len", 64'(n >= 16), 64'd1);
        // Leaving auto mode mid-step must not abort the step
        auto_mode = 1'b0;
        deadband  = 32'hFFFF_FFFF;
        tick();
        tick();
        psdone = 1'b1;
        tick();
        psdone = 1'b0;
        check("auto2_ps_count", 64'(ps_count), 64'd2);
        tick();
        tick();
        psdone = 1'b1;
        tick();
        psdone = 1'b0;
        tick();
        check("gap_psdone_ignored", 64'(ps_count), 64'd2);
        wait_idle();

        // E: manual increment, psdone coincides with timeout expiry
        man_psen   = 1'b1;
        man_incdec = 1'b1;
        tick();
        man_psen = 1'b0;
        check("man_psen", 64'(psen), 64'd1);
        for (int i = 0; i < 64; i++) tick();
        psdone = 1'b1;
        tick();
        psdone = 1'b0;
        check("edge_ps_count", 64'(ps_count),    64'd3);
        check("edge_timeout",  64'(timeout_err), 64'd0);
        wait_idle();

        // F: manual decrement with psdone never returned
        man_psen   = 1'b1;
        man_incdec = 1'b0;
        tick();
        man_psen = 1'b0;
        check("tmo_psen",     64'(psen),     64'd1);
        check("tmo_psincdec", 64'(psincdec), 64'd0);
        n = 0;
        while (!timeout_err && n < 200) begin
            tick();
            n++;
        end
        check("tmo_latency",  64'(n >= 64 && n <= 66), 64'd1);
        check("tmo_ps_count", 64'(ps_count), 64'd3);
        for (int i = 0; i < 14; i++) tick();
        check("tmo_gap_busy", 64'(busy), 64'd1);
        tick();
        tick();
        check("tmo_idle",   64'(busy),        64'd0);
        check("tmo_sticky", 64'(timeout_err), 64'd1);

        // G: reset during WAIT_DONE with coincident psdone
        man_psen   = 1'b1;
        man_incdec = 1'b1;
        tick();
        man_psen = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        reset_in_n = 1'b0;
        psdone     = 1'b1;
        tick();
        reset_in_n = 1'b1;
        psdone     = 1'b0;
        check("rstmid_ps_count", 64'(ps_count),    64'd0);
        check("rstmid_busy",     64'(busy),        64'd0);
        check("rstmid_psen",     64'(psen),        64'd0);
        check("rstmid_timeout",  64'(timeout_err), 64'd0);
        tick();
        check("rstmid_psen_after", 64'(psen), 64'd0);

        // H: saturation in both directions
        do_reset();
        push(32'h7FFF_FFF0);
        check("sat_load", 64'(accum_out), 64'h7FFF_FFF0);
        push(32'h0000_0100);
        check("sat_pos",  64'(accum_out), 64'h7FFF_FFFF);
        push(32'hFFFF_FFFF);
        check("sat_dec",  64'(accum_out), 64'h7FFF_FFFE);
        push(32'h8000_0000);
        check("sat_mix",  64'(accum_out), 64'hFFFF_FFFE);
        push(32'h8000_0000);
        check("sat_neg",  64'(accum_out), 64'h8000_0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ps_servo_ctrl.md
PS_SERVO_CTRL -- requirements
Module: ps_servo_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32, signed width of the error, accumulator and filter datapath.
REQ-002 SHALL have parameter FILT_LOG2, default 3, setting the moving-average depth to 2^FILT_LOG2 samples (legal range 0..6).
REQ-003 SHALL have parameter MIN_GAP, default 16, the minimum number of idle cycles between the end of one step and the next psen.
REQ-004 SHALL have parameter DONE_TIMEOUT, default 64, the maximum number of cycles to wait for psdone.
REQ-005 SHALL have one clock and a synchronous, active-low reset, with ports as follows.
REQ-006 clk  in  1  single clock; all logic runs on its rising edge.
REQ-007 reset_in_n  in  1  synchronous, active-low reset.
REQ-008 err_valid  in  1  one-cycle qualifier for err_in.
REQ-009 err_in  in  WIDTH  signed phase-error sample.
REQ-010 auto_mode  in  1  1 = servo drives steps; 0 = manual steps.
REQ-011 hold  in  1  freezes the accumulator and inhibits auto steps.
REQ-012 deadband  in  WIDTH  unsigned magnitude threshold for auto steps.
REQ-013 man_psen  in  1  manual step request, level sampled in IDLE.
REQ-014 man_incdec  in  1  manual step direction.
REQ-015 psdone  in  1  MMCM phase-shift completion.
REQ-016 psen  out  1  one-cycle MMCM phase-shift enable.
REQ-017 psincdec  out  1  step direction, held stable from psen through psdone.
REQ-018 accum_out  out  WIDTH  signed saturating accumulator.
REQ-019 filt_out  out  WIDTH  signed moving-average output.
REQ-020 ps_count  out  32  signed net count of completed steps.
REQ-021 busy  out  1  high in every state other than IDLE.
REQ-022 timeout_err  out  1  sticky flag, set when psdone is missed.

Function
REQ-023 On err_valid with hold=0: accum_out SHALL become accum_out+err_in, saturated to the signed WIDTH max/min, with a 1-cycle latency.
REQ-024 On err_valid with hold=1: accum_out SHALL stay unchanged.
REQ-025 On err_valid: the filter SHALL push the post-update accumulator value into a 2^FILT_LOG2-entry circular buffer.
REQ-026 The filter SHALL keep a running sum of WIDTH+FILT_LOG2 bits (add the new entry, subtract the evicted one).
REQ-027 filt_out SHALL equal the running sum arithmetic-shifted right by FILT_LOG2, valid 1 cycle after the push.
REQ-028 Until 2^FILT_LOG2 pushes have occurred since reset, unfilled buffer entries SHALL read as 0.
REQ-029 The step FSM SHALL have states IDLE, PULSE, WAIT_DONE and GAP.
REQ-030 IDLE->PULSE (auto) when auto_mode=1, hold=0 and |filt_out|>deadband; psincdec<=1 if filt_out>0, else 0.
REQ-031 IDLE->PULSE (manual) when auto_mode=0 and man_psen=1; psincdec<=man_incdec.
REQ-032 PULSE: psen=1 for exactly one cycle, then ->WAIT_DONE.
REQ-033 WAIT_DONE: on psdone, ps_count SHALL change by +1 (psincdec=1) or -1 (psincdec=0), wrapping at 32 bits, then ->GAP.
REQ-034 WAIT_DONE: after DONE_TIMEOUT cycles without psdone, timeout_err<=1 and ->GAP; ps_count SHALL stay unchanged.
REQ-035 GAP: count MIN_GAP cycles, then ->IDLE.
REQ-036 psdone received in any state other than WAIT_DONE SHALL be ignored.
REQ-037 psdone arriving in the same cycle as the timeout expiry SHALL count as done; timeout_err SHALL not be set.
REQ-038 Changes to auto_mode, hold or deadband outside IDLE SHALL not abort a step in progress.
REQ-039 psen SHALL never assert twice without an intervening psdone or timeout plus MIN_GAP cycles.
REQ-040 err_valid SHALL be accepted in every FSM state (accumulator and filter are independent of the FSM).

Reset
REQ-041 While reset_in_n=0 at a clk edge: FSM<=IDLE; psen, psincdec, busy, timeout_err <= 0; accum_out, filt_out, ps_count, running sum and all buffer entries <= 0; fill count <= 0.
REQ-042 Reset asserted mid-step SHALL abort the step with no ps_count update; psen SHALL be 0 in the first cycle after reset.
REQ-043 timeout_err SHALL be cleared only by reset.

Verification
REQ-044 WIDTH=32, FILT_LOG2=3: 8 samples err_in=+100 -> accum_out=800; filt_out=450 after the 8th push (sum 3600>>>3).
REQ-045 auto_mode=1, deadband=10, filt_out=+50, psdone returned 5 cycles after psen -> one psen pulse, psincdec=1, ps_count=+1, next psen no earlier than MIN_GAP=16 cycles after psdone.
REQ-046 auto_mode=0, man_psen=1, man_incdec=0, psdone never returned -> psen once, timeout_err=1 after 64 cycles, ps_count=0, FSM back in IDLE after a further 16 cycles.
REQ-047 accum_out=0x7FFFFFF0, err_in=+0x100 -> accum_out=0x7FFFFFFF; then err_in=-1 -> accum_out=0x7FFFFFFE.
REQ-048 reset_in_n driven low in WAIT_DONE, psdone pulsed in the same cycle -> ps_count=0, busy=0, psen=0 on the next cycle.
REQ-049 hold=1 with 4 err_valid samples of +7 -> accum_out unchanged, no psen asserted.
